// File: rtl/fpu_op_scheduler_pkg.sv
// Shared types and constants for the FPU op scheduler: FSM state encoding,
// funct3 op codes, the request bundle and the per-op latency lookup.
package fpu_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } sched_state_e;

    localparam logic [2:0] FADD = 3'b000;
    localparam logic [2:0] FSUB = 3'b001;
    localparam logic [2:0] FMUL = 3'b010;
    localparam logic [2:0] FDIV = 3'b011;

    localparam int CNT_W = 4;

    typedef struct packed {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [2:0]  funct3;
    } fpu_req_t;

    // EXEC length in cycles for an op; anything outside FADD..FDIV is illegal.
    function automatic logic [CNT_W-1:0] lat_lookup(input logic [2:0] f3,
                                                    input int lat_add,
                                                    input int lat_mul,
                                                    input int lat_div,
                                                    input int lat_ill);
        int l;
        case (f3)
            FADD, FSUB: l = lat_add;
            FMUL:       l = lat_mul;
            FDIV:       l = lat_div;
            default:    l = lat_ill;
        endcase
        return l[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/fpu_op_scheduler_if.sv
// Request, FPU and response signals of the scheduler. The slave side is the
// scheduler; the master side is the requesters, the FPU and the consumer.
interface fpu_op_scheduler_if;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_rs1, req0_rs2, req1_rs1, req1_rs2;
    logic [2:0]  req0_funct3, req1_funct3;
    logic        flush;
    logic [31:0] fpu_rs1, fpu_rs2;
    logic [2:0]  fpu_funct3;
    logic [31:0] fpu_result;
    logic        fpu_valid;
    logic        resp_valid, resp_ready;
    logic        resp_id;
    logic [31:0] resp_result;
    logic        resp_illegal;
    logic        busy;

    modport slave (
        input  req0_valid, req1_valid, req0_rs1, req0_rs2, req1_rs1, req1_rs2,
               req0_funct3, req1_funct3, flush, fpu_result, fpu_valid, resp_ready,
        output req0_ready, req1_ready, fpu_rs1, fpu_rs2, fpu_funct3,
               resp_valid, resp_id, resp_result, resp_illegal, busy
    );

    modport master (
        output req0_valid, req1_valid, req0_rs1, req0_rs2, req1_rs1, req1_rs2,
               req0_funct3, req1_funct3, flush, fpu_result, fpu_valid, resp_ready,
        input  req0_ready, req1_ready, fpu_rs1, fpu_rs2, fpu_funct3,
               resp_valid, resp_id, resp_result, resp_illegal, busy
    );
endinterface

// File: rtl/fpu_rr_arbiter.sv
// 2-way round-robin arbiter. A lone requester always wins; on contention
// rr_ptr picks the winner. Grant is suppressed entirely when not enabled.
module fpu_rr_arbiter (
    input  logic [1:0] valid,
    input  logic       rr_ptr,
    input  logic       enable,
    output logic [1:0] grant,
    output logic       gnt_id
);

    // Pick the winner id, then form a one-hot grant gated by enable.
    always_comb begin
        gnt_id = 1'b0;
        if (valid == 2'b11)
            gnt_id = rr_ptr;
        else if (valid[1])
            gnt_id = 1'b1;
        grant = 2'b00;
        if (enable && (|valid))
            grant[gnt_id] = 1'b1;
    end

endmodule

// File: rtl/fpu_op_scheduler.sv
// Sequencer in front of the combinational FPU: arbitrates two requesters,
// holds operands on the FPU for the op's latency budget, captures the result
// on the last EXEC cycle and hands it out over a valid/ready channel.
module fpu_op_scheduler
    import fpu_sched_pkg::*;
#(
    parameter int LAT_ADD = 2,
    parameter int LAT_MUL = 3,
    parameter int LAT_DIV = 8,
    parameter int LAT_ILL = 1
) (
    input logic              clk,
    input logic              rst_n,
    fpu_op_scheduler_if.slave bus
);

    sched_state_e     state;
    logic [CNT_W-1:0] cnt;
    logic             rr_ptr;
    logic [1:0]       grant;
    logic             gnt_id;
    logic             accept;
    logic             capture;
    fpu_req_t         req_sel;

    logic [31:0] fpu_rs1_q, fpu_rs2_q, resp_result_q;
    logic [2:0]  fpu_funct3_q;
    logic        resp_id_q, resp_illegal_q;

    fpu_rr_arbiter u_arb (
        .valid  ({bus.req1_valid, bus.req0_valid}),
        .rr_ptr (rr_ptr),
        .enable ((state == ST_IDLE) && !bus.flush),
        .grant  (grant),
        .gnt_id (gnt_id)
    );

    assign bus.req0_ready = grant[0];
    assign bus.req1_ready = grant[1];
    assign accept         = |grant;

    assign req_sel = gnt_id ? fpu_req_t'{bus.req1_rs1, bus.req1_rs2, bus.req1_funct3}
                            : fpu_req_t'{bus.req0_rs1, bus.req0_rs2, bus.req0_funct3};

    // A flush landing on the last EXEC cycle wins: nothing is captured.
    assign capture = (state == ST_EXEC) && (cnt == '0) && !bus.flush;

    // Control FSM, latency counter and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            rr_ptr <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (accept) begin
                    state  <= ST_EXEC;
                    cnt    <= lat_lookup(req_sel.funct3, LAT_ADD, LAT_MUL, LAT_DIV, LAT_ILL) - 1'b1;
                    rr_ptr <= ~gnt_id;
                end
                ST_EXEC: begin
                    if (bus.flush)
                        state <= ST_IDLE;
                    else if (cnt == '0)
                        state <= ST_RESP;
                    else
                        cnt <= cnt - 1'b1;
                end
                ST_RESP: if (bus.flush || bus.resp_ready) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Operand latch on accept and result capture on the final EXEC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpu_rs1_q      <= '0;
            fpu_rs2_q      <= '0;
            fpu_funct3_q   <= '0;
            resp_id_q      <= 1'b0;
            resp_result_q  <= '0;
            resp_illegal_q <= 1'b0;
        end else begin
            if (accept) begin
                fpu_rs1_q    <= req_sel.rs1;
                fpu_rs2_q    <= req_sel.rs2;
                fpu_funct3_q <= req_sel.funct3;
                resp_id_q    <= gnt_id;
            end
            if (capture) begin
                resp_result_q  <= bus.fpu_result;
                resp_illegal_q <= ~bus.fpu_valid;
            end
        end
    end

    assign bus.fpu_rs1      = fpu_rs1_q;
    assign bus.fpu_rs2      = fpu_rs2_q;
    assign bus.fpu_funct3   = fpu_funct3_q;
    assign bus.resp_valid   = (state == ST_RESP);
    assign bus.resp_id      = resp_id_q;
    assign bus.resp_result  = resp_result_q;
    assign bus.resp_illegal = resp_illegal_q;
    assign bus.busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_fpu_op_scheduler.sv
// Bench for fpu_op_scheduler: directed scenarios followed by random ops,
// checked against a transaction-level model (latency table, rr pointer,
// stub FPU function).
module tb_fpu_op_scheduler;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   rr_m  = 0;

    fpu_op_scheduler_if bus ();

    fpu_op_scheduler dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] fpu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic [2:0] f3);
        if (f3[2]) return 32'h0;
        if (f3 == 3'b000 && a == 32'h3F800000 && b == 32'h40000000) return 32'h40400000;
        return a ^ {b[15:0], b[31:16]} ^ {29'h0, f3} ^ 32'h5A5A0000;
    endfunction

    function automatic int lat_of(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b001: return 2;
            3'b010:         return 3;
            3'b011:         return 8;
            default:        return 1;
        endcase
    endfunction

    // Stub FPU: combinational from the operands the scheduler drives.
    always_comb begin
        bus.fpu_valid  = ~bus.fpu_funct3[2];
        bus.fpu_result = fpu_fn(bus.fpu_rs1, bus.fpu_rs2, bus.fpu_funct3);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".req0_ready"}, 32'(bus.req0_ready), 0);
        chk({tag, ".req1_ready"}, 32'(bus.req1_ready), 0);
        chk({tag, ".fpu_rs1"}, bus.fpu_rs1, 0);
        chk({tag, ".fpu_rs2"}, bus.fpu_rs2, 0);
        chk({tag, ".fpu_funct3"}, 32'(bus.fpu_funct3), 0);
        chk({tag, ".resp_valid"}, 32'(bus.resp_valid), 0);
        chk({tag, ".resp_id"}, 32'(bus.resp_id), 0);
        chk({tag, ".resp_result"}, bus.resp_result, 0);
        chk({tag, ".resp_illegal"}, 32'(bus.resp_illegal), 0);
        chk({tag, ".busy"}, 32'(bus.busy), 0);
    endtask

    task automatic scramble_req();
        bus.req0_rs1 = $urandom; bus.req0_rs2 = $urandom; bus.req0_funct3 = 3'($urandom);
        bus.req1_rs1 = $urandom; bus.req1_rs2 = $urandom; bus.req1_funct3 = 3'($urandom);
    endtask

    // One transaction. who: 0/1 single requester, 2 both. Called at posedge+1
    // with the DUT idle; flush_at: EXEC cycle (1..LAT) to flush in, 0 = none.
    task automatic run_op(input int who, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input int hold, input int flush_at,
                          input bit flush_resp);
        int e, lat;
        logic [31:0] exp_res;
        e = (who == 2) ? rr_m : who;
        lat = lat_of(f3);
        exp_res = fpu_fn(a, b, f3);
        scramble_req();
        bus.req0_valid = (who != 1);
        bus.req1_valid = (who != 0);
        if (e == 0) begin bus.req0_rs1 = a; bus.req0_rs2 = b; bus.req0_funct3 = f3; end
        else        begin bus.req1_rs1 = a; bus.req1_rs2 = b; bus.req1_funct3 = f3; end
        #4;
        chk("grant.req0_ready", 32'(bus.req0_ready), 32'(e == 0));
        chk("grant.req1_ready", 32'(bus.req1_ready), 32'(e == 1));
        step();
        rr_m = 1 - e;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        scramble_req();
        for (int c = 1; c <= lat; c++) begin
            bus.flush = (c == flush_at);
            #4;
            chk("exec.resp_valid", 32'(bus.resp_valid), 0);
            chk("exec.busy", 32'(bus.busy), 1);
            chk("exec.fpu_funct3", 32'(bus.fpu_funct3), 32'(f3));
            chk("exec.fpu_rs1", bus.fpu_rs1, a);
            chk("exec.fpu_rs2", bus.fpu_rs2, b);
            step();
            if (c == flush_at) begin
                bus.flush = 1'b0;
                #4;
                chk("flush.busy", 32'(bus.busy), 0);
                for (int k = 0; k < lat + 2; k++) begin
                    chk("flush.no_resp", 32'(bus.resp_valid), 0);
                    step();
                end
                return;
            end
        end
        // RESP: hold under backpressure with both requesters knocking.
        for (int h = 0; h <= hold; h++) begin
            bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
            bus.resp_ready = (h == hold) && !flush_resp;
            bus.flush      = (h == hold) && flush_resp;
            #4;
            chk("resp.resp_valid", 32'(bus.resp_valid), 1);
            chk("resp.resp_id", 32'(bus.resp_id), 32'(e));
            chk("resp.resp_result", bus.resp_result, exp_res);
            chk("resp.resp_illegal", 32'(bus.resp_illegal), 32'(f3[2]));
            chk("resp.busy", 32'(bus.busy), 1);
            chk("resp.req0_ready", 32'(bus.req0_ready), 0);
            chk("resp.req1_ready", 32'(bus.req1_ready), 0);
            step();
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.resp_ready = 1'b0; bus.flush = 1'b0;
        #4;
        chk("done.resp_valid", 32'(bus.resp_valid), 0);
        chk("done.busy", 32'(bus.busy), 0);
        step();
    endtask

    initial begin
        int who, hold, fl, lat;
        logic [2:0] f3;
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.flush = 1'b0; bus.resp_ready = 1'b0;
        scramble_req();

        // Reset state.
        #2;
        chk_zero("reset");
        step();
        rst_n = 1'b1;
        step();

        // Single FADD from req0.
        run_op(0, 3'b000, 32'h3F800000, 32'h40000000, 0, 0, 0);
        // FMUL then FDIV from req1.
        run_op(1, 3'b010, 32'h40400000, 32'h40800000, 0, 0, 0);
        run_op(1, 3'b011, 32'h41200000, 32'h40000000, 0, 0, 0);
        // Contention: grants alternate 0,1,0,1 (last op was req1 -> rr favours 0).
        for (int i = 0; i < 4; i++)
            run_op(2, 3'(i), $urandom, $urandom, 0, 0, 0);
        // Backpressure for 5 cycles.
        run_op(0, 3'b001, 32'h12345678, 32'h9ABCDEF0, 5, 0, 0);
        // Flush in 2nd EXEC cycle of FDIV; flush during RESP.
        run_op(0, 3'b011, 32'hCAFEF00D, 32'h0BADBEEF, 0, 2, 0);
        run_op(1, 3'b000, 32'h11111111, 32'h22222222, 2, 0, 1);
        // Illegal op.
        run_op(0, 3'b101, 32'hDEADBEEF, 32'h01234567, 0, 0, 0);

        // Async reset mid-EXEC of a req0 FDIV (rr would be 1 afterwards).
        bus.req0_valid = 1'b1;
        bus.req0_funct3 = 3'b011; bus.req0_rs1 = 32'hA5A5A5A5; bus.req0_rs2 = 32'h5A5A5A5A;
        step();
        bus.req0_valid = 1'b0;
        step();
        chk("pre_reset.busy", 32'(bus.busy), 1);
        rst_n = 1'b0;
        #1;
        chk_zero("mid_exec_reset");
        step();
        rst_n = 1'b1;
        rr_m = 0;
        step();
        run_op(2, 3'b010, 32'h3F000000, 32'h3F000000, 0, 0, 0);

        // Random ops against the model.
        for (int i = 0; i < 40; i++) begin
            who  = $urandom_range(0, 2);
            f3   = 3'($urandom_range(0, 7));
            lat  = lat_of(f3);
            hold = $urandom_range(0, 3);
            fl   = ($urandom_range(0, 5) == 0) ? $urandom_range(1, lat) : 0;
            run_op(who, f3, $urandom, $urandom, hold, fl, $urandom_range(0, 5) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
